// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO controller and its wrapper.
package fifo_pkg;

   localparam int A_WIDTH_DEF = 3;

   // Pointer width: one bit per address line.
   function automatic int ptr_width(input int a_width);
      return a_width;
   endfunction

   // Counter width: one extra bit so that the value DEPTH can be represented.
   function automatic int cnt_width(input int a_width);
      return a_width + 1;
   endfunction

   // Number of RAM words addressed by a_width address bits.
   function automatic int depth_of(input int a_width);
      return 1 << a_width;
   endfunction

   typedef logic [ptr_width(A_WIDTH_DEF)-1:0] ptr_t;
   typedef logic [cnt_width(A_WIDTH_DEF)-1:0] cnt_t;

endpackage

// File: rtl/sync_fifo.sv
// Complete FIFO: controller plus LUT RAM with asynchronous (show-ahead) read.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int A_WIDTH  = 3,
   parameter int D_WIDTH  = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_req,
   input  logic                          rd_req,
   input  logic [D_WIDTH-1:0]            w_data,
   output logic [D_WIDTH-1:0]            r_data,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [cnt_width(A_WIDTH)-1:0] count,
   output logic                          ovf_err,
   output logic                          udf_err
);

   localparam int DEPTH = depth_of(A_WIDTH);

   logic                          we;
   logic [ptr_width(A_WIDTH)-1:0] w_add, r_add;
   logic [D_WIDTH-1:0]            mem [DEPTH];

   fifo_ctrl #(
      .A_WIDTH  (A_WIDTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .we           (we),
      .w_add        (w_add),
      .r_add        (r_add),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .ovf_err      (ovf_err),
      .udf_err      (udf_err)
   );

   // RAM write port; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (we) mem[w_add] <= w_data;
   end

   assign r_data = mem[r_add];

endmodule

// File: rtl/fifo_ctrl.sv
// Show-ahead synchronous FIFO controller driving an async-read two-port RAM.
// Handshake: a push is taken when wr_req is high and there is room (or a pop
// is taken in the same cycle); a pop is taken when rd_req is high and the FIFO
// is not empty. Rejected requests only raise a one-cycle error pulse.
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int A_WIDTH  = 3,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_req,
   input  logic                              rd_req,
   output logic                              we,
   output logic [ptr_width(A_WIDTH)-1:0]     w_add,
   output logic [ptr_width(A_WIDTH)-1:0]     r_add,
   output logic                              full,
   output logic                              empty,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic [cnt_width(A_WIDTH)-1:0]     count,
   output logic                              ovf_err,
   output logic                              udf_err
);

   localparam int PW    = ptr_width(A_WIDTH);
   localparam int CW    = cnt_width(A_WIDTH);
   localparam int DEPTH = depth_of(A_WIDTH);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic          AF_RST  = (AF_LEVEL == 0);

   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          wr_ok, rd_ok;

   // Acceptance from registered flags; a pop frees a slot for a push while full.
   always_comb begin
      rd_ok   = rd_req & ~empty;
      wr_ok   = wr_req & (~full | rd_ok);
      cnt_nxt = cnt + CW'(wr_ok) - CW'(rd_ok);
   end

   assign we    = wr_ok & ~rst;
   assign w_add = wptr;
   assign r_add = rptr;
   assign count = cnt;

   // Pointers, occupancy, flags (from next count) and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr         <= '0;
         rptr         <= '0;
         cnt          <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= AF_RST;
         ovf_err      <= 1'b0;
         udf_err      <= 1'b0;
      end else begin
         wptr         <= wptr + PW'(wr_ok);
         rptr         <= rptr + PW'(rd_ok);
         cnt          <= cnt_nxt;
         empty        <= (cnt_nxt == '0);
         full         <= (cnt_nxt == DEPTH_C);
         almost_empty <= (cnt_nxt <= AE_C);
         almost_full  <= (cnt_nxt >= AF_C);
         ovf_err      <= wr_req & ~wr_ok;
         udf_err      <= rd_req & ~rd_ok;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl, with a sync_fifo alongside for data checks.
module tb_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_req = 1'b0;
   logic       rd_req = 1'b0;
   logic [7:0] w_data = '0;

   logic       we, full, empty, almost_full, almost_empty, ovf_err, udf_err;
   logic [2:0] w_add, r_add;
   logic [3:0] count;

   logic [7:0] f_r_data;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [3:0] f_count;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_w;

   always #5 clk = ~clk;

   fifo_ctrl #(.A_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .we           (we),
      .w_add        (w_add),
      .r_add        (r_add),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .ovf_err      (ovf_err),
      .udf_err      (udf_err)
   );

   sync_fifo #(.A_WIDTH(3), .D_WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .w_data       (w_data),
      .r_data       (f_r_data),
      .full         (f_full),
      .empty        (f_empty),
      .almost_full  (f_af),
      .almost_empty (f_ae),
      .count        (f_count),
      .ovf_err      (f_ovf),
      .udf_err      (f_udf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Apply inputs shortly after an edge and let combinational outputs settle.
   task automatic drive(input logic wr, input logic rd, input logic [7:0] d);
      wr_req = wr;
      rd_req = rd;
      w_data = d;
      #1;
   endtask

   // Advance one edge and sample registered outputs away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- reset ----
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      tick();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ae", almost_empty, 1);
      check("rst_af", almost_full, 0);
      check("rst_ovf", ovf_err, 0);
      check("rst_udf", udf_err, 0);
      check("rst_wadd", w_add, 0);
      check("rst_radd", r_add, 0);
      rst = 1'b0;

      // ---- 1: eight pushes 0x10..0x17 ----
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'h10 + 8'(i));
         check("fill_we", we, 1);
         check("fill_wadd", w_add, i);
         exp_q.push_back(8'h10 + 8'(i));
         tick();
         check("fill_count", count, i + 1);
         check("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
         check("fill_full", full, (i + 1 == 8) ? 1 : 0);
         check("fill_ae", almost_empty, (i + 1 <= 1) ? 1 : 0);
         check("fill_empty", empty, 0);
      end
      check("fill_wrap", w_add, 0);

      // ---- 2: push while full ----
      drive(1'b1, 1'b0, 8'hee);
      check("ovf_we", we, 0);
      tick();
      check("ovf_pulse", ovf_err, 1);
      check("ovf_count", count, 8);
      check("ovf_wadd", w_add, 0);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      check("ovf_clear", ovf_err, 0);

      // ---- 3: push 0x20 + pop while full ----
      drive(1'b1, 1'b1, 8'h20);
      check("pp_rdata", f_r_data, 8'h10);
      exp_w = exp_q.pop_front();
      check("pp_rdata_q", f_r_data, exp_w);
      check("pp_we", we, 1);
      exp_q.push_back(8'h20);
      tick();
      check("pp_count", count, 8);
      check("pp_radd", r_add, 1);
      check("pp_wadd", w_add, 1);
      check("pp_full", full, 1);
      check("pp_ovf", ovf_err, 0);

      // ---- 4: drain all eight ----
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 8'h00);
         if (exp_q.size() == 0) begin
            check("drain_q_underrun", exp_q.size(), 1);
         end else begin
            exp_w = exp_q.pop_front();
            check("drain_rdata", f_r_data, exp_w);
         end
         tick();
         check("drain_count", count, 7 - i);
      end
      check("drain_empty", empty, 1);
      check("drain_ae", almost_empty, 1);
      check("drain_full", full, 0);
      check("drain_radd", r_add, 1);
      // extra pop on empty
      drive(1'b0, 1'b1, 8'h00);
      tick();
      check("udf_pulse", udf_err, 1);
      check("udf_count", count, 0);
      check("udf_radd", r_add, 1);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      check("udf_clear", udf_err, 0);

      // ---- 5: push 0x55 + pop while empty ----
      drive(1'b1, 1'b1, 8'h55);
      check("ep_we", we, 1);
      tick();
      check("ep_udf", udf_err, 1);
      check("ep_count", count, 1);
      check("ep_empty", empty, 0);
      drive(1'b0, 1'b0, 8'h00);
      check("ep_rdata", f_r_data, 8'h55);
      drive(1'b0, 1'b1, 8'h00);
      tick();
      check("ep_pop_count", count, 0);
      check("ep_pop_udf", udf_err, 0);

      // ---- 6: reset mid-stream at count 5 ----
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 8'h30 + 8'(i));
         tick();
      end
      check("pre_rst_count", count, 5);
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h99);
      check("rst_we_forced", we, 0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      check("mid_rst_count", count, 0);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_wadd", w_add, 0);
      check("mid_rst_radd", r_add, 0);
      check("mid_rst_full", full, 0);
      check("mid_rst_ovf", ovf_err, 0);
      check("mid_rst_f_count", f_count, 0);
      check("mid_rst_f_flags", {f_full, f_empty, f_af, f_ae, f_ovf, f_udf}, 6'b010100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
